// File: rtl/dmem_arb_pkg.sv
// Shared types, funct3 encodings and the access-fault rule for the data-memory arbiter.
// Combinational helpers only; no latency of its own.
// No flow control here; the arbiter FSM owns the handshake.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Faults: misaligned halfword/word, reserved encodings, and load-only sizes used as stores.
    function automatic logic is_fault(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
        logic f;
        f = 1'b1;
        if (we) begin
            case (funct3)
                F3_SB:   f = 1'b0;
                F3_SH:   f = addr_lo[0];
                F3_SW:   f = |addr_lo;
                default: f = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: f = 1'b0;
                F3_LH, F3_LHU: f = addr_lo[0];
                F3_LW:         f = |addr_lo;
                default:       f = 1'b1;
            endcase
        end
        return f;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick: on a tie the port that did not win last time is chosen.
// Purely combinational, zero latency.
// Grants nothing while enable is low; requesters simply keep req asserted.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       grant_id
);

    // Select the winner; a tie goes to the port opposite last_grant.
    always_comb begin
        grant_id = 1'b0;
        grant    = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant_id = 1'b0;
                2'b10:   grant_id = 1'b1;
                2'b11:   grant_id = ~last_grant;
                default: grant_id = 1'b0;
            endcase
            if (|req)
                grant = grant_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between the core port (0) and the debug/DMA port (1), round-robin.
// Fixed 3-cycle transaction: grant pulse in ACCESS, completion pulse in RESP.
// Requesters hold req until gnt; requests seen outside IDLE wait and are never dropped.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [DM_ADDRESS-1:0] addr0,
    input  logic [DM_ADDRESS-1:0] addr1,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [2:0]            funct3_0,
    input  logic [2:0]            funct3_1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_W-1:0]     rdata0,
    output logic [DATA_W-1:0]     rdata1,
    output logic                  err0,
    output logic                  err1,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rd
);

    state_t                state;
    logic                  last_grant;
    logic                  port_q;
    logic                  we_q;
    logic                  fault_q;

    logic [1:0]            grant;
    logic                  grant_id;
    logic                  we_s;
    logic [DM_ADDRESS-1:0] addr_s;
    logic [DATA_W-1:0]     wdata_s;
    logic [2:0]            funct3_s;
    logic                  fault_s;

    rr_arbiter2 u_rr (
        .req        ({req1, req0}),
        .last_grant (last_grant),
        .enable     (state == IDLE),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    // Steer the winning port's fields and classify the access before latching it.
    always_comb begin
        we_s     = grant_id ? we1      : we0;
        addr_s   = grant_id ? addr1    : addr0;
        wdata_s  = grant_id ? wdata1   : wdata0;
        funct3_s = grant_id ? funct3_1 : funct3_0;
        fault_s  = is_fault(we_s, funct3_s, addr_s[1:0]);
    end

    // Transaction sequencer; every output is registered so memory strobes are glitch-free.
    // The mem_a/mem_wd/mem_funct3 registers double as the request latches: they are loaded
    // on grant and only meaningful during ACCESS. A faulting access never reaches memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            fault_q    <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;
            mem_funct3 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        port_q     <= grant_id;
                        we_q       <= we_s;
                        fault_q    <= fault_s;
                        last_grant <= grant_id;
                        gnt0       <= grant[0];
                        gnt1       <= grant[1];
                        mem_read   <= ~fault_s & ~we_s;
                        mem_write  <= ~fault_s &  we_s;
                        mem_a      <= fault_s ? '0 : addr_s;
                        mem_wd     <= fault_s ? '0 : wdata_s;
                        mem_funct3 <= fault_s ? '0 : funct3_s;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    gnt0       <= 1'b0;
                    gnt1       <= 1'b0;
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                    mem_a      <= '0;
                    mem_wd     <= '0;
                    mem_funct3 <= '0;
                    rvalid0    <= ~port_q;
                    rvalid1    <=  port_q;
                    err0       <= ~port_q & fault_q;
                    err1       <=  port_q & fault_q;
                    rdata0     <= (!port_q && !we_q && !fault_q) ? mem_rd : '0;
                    rdata1     <= ( port_q && !we_q && !fault_q) ? mem_rd : '0;
                    state      <= RESP;
                end
                RESP: begin
                    rvalid0 <= 1'b0;
                    rvalid1 <= 1'b0;
                    err0    <= 1'b0;
                    err1    <= 1'b0;
                    rdata0  <= '0;
                    rdata1  <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with per-port expectation queues checked by a monitor.
// Runs a fixed sequence of accesses; memory read data is a simple address-dependent model.
// Requesters hold req until gnt and drop it in the grant cycle.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [8:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [2:0]  funct3_0, funct3_1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_read, mem_write;
    logic [8:0]  mem_a;
    logic [31:0] mem_wd;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rd;
    logic [31:0] mem_data;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [8:0]  a;
        logic [31:0] wd;
        logic [2:0]  f3;
    } gexp_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } rexp_t;

    gexp_t gq0[$], gq1[$];
    rexp_t rq0[$], rq1[$];
    int    glog_port[$];
    int    glog_cyc[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .funct3_0   (funct3_0),
        .funct3_1   (funct3_1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .err0       (err0),
        .err1       (err1),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_funct3 (mem_funct3),
        .mem_rd     (mem_rd)
    );

    // Memory model: read data depends on address so a wrong capture point shows up.
    assign mem_rd = mem_read ? (mem_data ^ {23'd0, mem_a}) : 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " strobes"}, 64'({gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write}), 64'd0);
        chk({name, " mem bus"}, 64'({mem_a, mem_wd, mem_funct3}), 64'd0);
        chk({name, " rdata0"}, 64'(rdata0), 64'd0);
        chk({name, " rdata1"}, 64'(rdata1), 64'd0);
    endtask

    task automatic chk_gnt(input int p, input gexp_t g);
        chk($sformatf("gnt%0d mem_read", p), 64'(mem_read), 64'(g.rd));
        chk($sformatf("gnt%0d mem_write", p), 64'(mem_write), 64'(g.wr));
        if (g.rd || g.wr) begin
            chk($sformatf("gnt%0d mem_a", p), 64'(mem_a), 64'(g.a));
            chk($sformatf("gnt%0d mem_funct3", p), 64'(mem_funct3), 64'(g.f3));
        end
        if (g.wr)
            chk($sformatf("gnt%0d mem_wd", p), 64'(mem_wd), 64'(g.wd));
    endtask

    // Monitor: compares every grant and completion against the queued expectations.
    always @(negedge clk) begin
        if (reset) begin
            chk("gnt overlap", 64'(gnt0 & gnt1), 64'd0);
            if (!(gnt0 || gnt1))
                chk("mem strobe outside access", 64'({mem_read, mem_write}), 64'd0);
            if (gnt0) begin
                glog_port.push_back(0);
                glog_cyc.push_back(cyc);
                chk("gnt0 expected", 64'(gq0.size() != 0), 64'd1);
                if (gq0.size() != 0) chk_gnt(0, gq0.pop_front());
            end
            if (gnt1) begin
                glog_port.push_back(1);
                glog_cyc.push_back(cyc);
                chk("gnt1 expected", 64'(gq1.size() != 0), 64'd1);
                if (gq1.size() != 0) chk_gnt(1, gq1.pop_front());
            end
            if (rvalid0) begin
                chk("rvalid0 expected", 64'(rq0.size() != 0), 64'd1);
                if (rq0.size() != 0) begin
                    rexp_t r;
                    r = rq0.pop_front();
                    chk("err0", 64'(err0), 64'(r.err));
                    chk("rdata0", 64'(rdata0), 64'(r.rdata));
                end
                chk("port1 quiet during rvalid0", 64'({rvalid1, err1, rdata1}), 64'd0);
            end else begin
                chk("port0 idle outputs", 64'({err0, rdata0}), 64'd0);
            end
            if (rvalid1) begin
                chk("rvalid1 expected", 64'(rq1.size() != 0), 64'd1);
                if (rq1.size() != 0) begin
                    rexp_t r;
                    r = rq1.pop_front();
                    chk("err1", 64'(err1), 64'(r.err));
                    chk("rdata1", 64'(rdata1), 64'(r.rdata));
                end
                chk("port0 quiet during rvalid1", 64'({rvalid0, err0, rdata0}), 64'd0);
            end else begin
                chk("port1 idle outputs", 64'({err1, rdata1}), 64'd0);
            end
        end
    end

    // One access on port p; expects the grant fields and completion given by the caller.
    // Called one time unit after a rising edge; returns at the same phase in the RESP cycle.
    task automatic do_req(input int p, input logic we, input logic [8:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input logic exp_err, input logic [31:0] exp_rdata,
                          input int exp_wait);
        gexp_t g;
        rexp_t r;
        int    waited;
        logic  got;
        g.rd = !we && !exp_err;
        g.wr = we && !exp_err;
        g.a  = a;
        g.wd = wd;
        g.f3 = f3;
        r.err   = exp_err;
        r.rdata = exp_rdata;
        if (p == 0) begin
            gq0.push_back(g); rq0.push_back(r);
            we0 = we; addr0 = a; wdata0 = wd; funct3_0 = f3; req0 = 1'b1;
        end else begin
            gq1.push_back(g); rq1.push_back(r);
            we1 = we; addr1 = a; wdata1 = wd; funct3_1 = f3; req1 = 1'b1;
        end
        waited = 0;
        got    = 1'b0;
        while (!got && waited < 30) begin
            @(posedge clk);
            #1;
            waited = waited + 1;
            got = (p == 0) ? gnt0 : gnt1;
        end
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        chk($sformatf("gnt%0d arrived", p), 64'(got), 64'd1);
        if (got) begin
            if (exp_wait > 0)
                chk($sformatf("gnt%0d latency", p), 64'(waited), 64'(exp_wait));
            @(posedge clk);
            #1;
            chk($sformatf("rvalid%0d one cycle after gnt", p),
                64'((p == 0) ? rvalid0 : rvalid1), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        funct3_0 = '0; funct3_1 = '0;
        mem_data = 32'hDEADBEFF;
        #2 reset = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        // Port 0 LW 0x010: read data 0xDEADBEFF ^ 0x010 = 0xDEADBEEF, grant after one edge.
        do_req(0, 1'b0, 9'h010, 32'h0, 3'b010, 1'b0, 32'hDEADBEEF, 1);
        @(posedge clk); #1;
        // Port 1 SW to 0x022 is misaligned: fault, no write strobe.
        do_req(1, 1'b1, 9'h022, 32'h00000055, 3'b010, 1'b1, 32'h0, 1);
        @(posedge clk); #1;
        // Port 0 SH to 0x006 with 0x0000ABCD is aligned: write goes out.
        do_req(0, 1'b1, 9'h006, 32'h0000ABCD, 3'b001, 1'b0, 32'h0, 1);
        @(posedge clk); #1;
        // Port 0 load with reserved funct3 111.
        do_req(0, 1'b0, 9'h000, 32'h0, 3'b111, 1'b1, 32'h0, 1);
        @(posedge clk); #1;
        // Port 1 LHU at odd address 0x005.
        do_req(1, 1'b0, 9'h005, 32'h0, 3'b101, 1'b1, 32'h0, 1);
        @(posedge clk); #1;
        // Port 0 store with load-only funct3 100.
        do_req(0, 1'b1, 9'h008, 32'h12345678, 3'b100, 1'b1, 32'h0, 1);
        @(posedge clk); #1;
        // Port 1 SB at 0x003: byte stores are legal at any alignment.
        do_req(1, 1'b1, 9'h003, 32'h000000EF, 3'b000, 1'b0, 32'h0, 1);
        @(posedge clk); #1;
        // Port 1 LB at 0x1FF: top address, byte load, data 0xDEADBEFF ^ 0x1FF = 0xDEADBF00.
        do_req(1, 1'b0, 9'h1FF, 32'h0, 3'b000, 1'b0, 32'hDEADBF00, 1);
        repeat (2) @(posedge clk);
        #1;

        // Reset asserted in the middle of an ACCESS cycle.
        mem_data = 32'h11110000;
        we0 = 1'b0; addr0 = 9'h010; funct3_0 = 3'b010; req0 = 1'b1;
        @(posedge clk); #1;
        chk("gnt0 before mid-access reset", 64'(gnt0), 64'd1);
        req0 = 1'b0;
        #1 reset = 1'b0;
        #1 chk_all_zero("mid-access reset");
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("quiet after reset release",
                64'({rvalid0, rvalid1, mem_read, mem_write, gnt0, gnt1}), 64'd0);
        end

        // Both ports held: from reset, grants alternate 0,1,0,1, one every 3 cycles.
        glog_port.delete();
        glog_cyc.delete();
        fork
            begin
                do_req(0, 1'b0, 9'h040, 32'h0, 3'b010, 1'b0, 32'h11110040, 1);
                do_req(0, 1'b0, 9'h042, 32'h0, 3'b001, 1'b0, 32'h11110042, 0);
            end
            begin
                do_req(1, 1'b0, 9'h080, 32'h0, 3'b010, 1'b0, 32'h11110080, 0);
                do_req(1, 1'b0, 9'h083, 32'h0, 3'b100, 1'b0, 32'h11110083, 0);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("tie grant count", 64'(glog_port.size()), 64'd4);
        if (glog_port.size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("tie grant order %0d", i), 64'(glog_port[i]), 64'(i % 2));
            for (int i = 1; i < 4; i++)
                chk($sformatf("tie grant spacing %0d", i),
                    64'(glog_cyc[i] - glog_cyc[i-1]), 64'd3);
        end

        chk("leftover expectations",
            64'(gq0.size() + gq1.size() + rq0.size() + rq1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer placed in front of the data memory. It shares the data memory between port 0 (core load/store path) and port 1 (debug/DMA loader).
- Uses a req/gnt/rvalid handshake and round-robin fairness.
- Latches each granted request and drives the memory for exactly one cycle. Misaligned or unsupported accesses are trapped before they reach memory.

Parameters:
- DM_ADDRESS, 9, width of the memory byte address.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request, per port.
- we0 / we1  in  1  1 = store, 0 = load.
- addr0 / addr1  in  DM_ADDRESS  byte address.
- wdata0 / wdata1  in  DATA_W  store data.
- funct3_0 / funct3_1  in  3  access size/sign (RISC-V load/store funct3).
- gnt0 / gnt1  out  1  one-cycle grant pulse.
- rvalid0 / rvalid1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  DATA_W  load result, valid with rvalid.
- err0 / err1  out  1  access fault, valid with rvalid.
- mem_read  out  1  to data memory MemRead.
- mem_write  out  1  to data memory MemWrite.
- mem_a  out  DM_ADDRESS  to data memory address.
- mem_wd  out  DATA_W  to data memory write data.
- mem_funct3  out  3  to data memory Funct3.
- mem_rd  in  DATA_W  from data memory read data (combinationally valid in the cycle mem_read is high).

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
  - All outputs 0; latched request registers 0.
  - Reset asserted mid-transaction aborts it: no rvalid and no memory strobe after reset is released.
- FSM states: IDLE, ACCESS, RESP. Each transaction takes exactly 3 cycles.
- IDLE:
  - If no req, stay in IDLE.
  - If only one req, grant that port.
  - If both, grant the port != last_grant.
  - On grant: latch we/addr/wdata/funct3/port id, set last_grant = port, compute fault, go to ACCESS.
- ACCESS:
  - gnt[port] = 1 for this cycle only.
  - If no fault: mem_read = ~we, mem_write = we, and mem_a/mem_wd/mem_funct3 are driven from the latches.
  - If fault: mem_read = mem_write = 0.
  - At the end of the cycle, register rdata = (load && !fault) ? mem_rd : 0. Go to RESP.
- RESP:
  - rvalid[port] = 1 and err[port] = fault; rdata[port] holds the registered value. The other port's outputs stay 0.
  - Next state is IDLE.
- Fault rules:
  - LW/SW (funct3 010) with addr[1:0] != 00.
  - LH/LHU/SH (001/101) with addr[0] != 0.
  - funct3 011, 110 or 111.
  - Stores with funct3 100 or 101.
- Requester rules:
  - Hold req and all fields stable until gnt.
  - Deassert req in the gnt cycle unless a new access is wanted; a req still high in IDLE after RESP is a new request.
- Outputs when idle: mem_* outputs are 0 outside ACCESS. rdata outputs are 0 except during RESP.
- Latency: req sampled at edge N, gnt during cycle N+1, rvalid during cycle N+2. Peak throughput is one access per 3 cycles.
- Simultaneous events: a req arriving during ACCESS or RESP is ignored until IDLE and is not lost if held. Fairness guarantees that a held request is served within 2 transactions.

Decomposition:
- Package dmem_arb_pkg:
  - state enum (IDLE, ACCESS, RESP).
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
  - function is_fault(we, funct3, addr[1:0]).
- One sub-module: rr_arbiter2 (inputs req[1:0], last_grant, enable; outputs grant one-hot and grant_id). It is combinational; last_grant stays in dmem_arbiter.

Test Plan:
- Reset, then req0 alone: LW addr 0x010. Check gnt0 on cycle 1 with mem_read=1 and mem_a=0x010; mem_rd=0xDEADBEEF gives rvalid0 on cycle 2 with rdata0=0xDEADBEEF and err0=0; port 1 outputs stay 0.
- req0 and req1 both held for 4 transactions from reset: grant order 0,1,0,1. Each transaction is exactly 3 cycles and no gnt overlaps.
- Port 1 SW addr 0x022: err1=1 on rvalid1, rdata1=0, and mem_write never asserts.
- Port 0 SH addr 0x006 with wdata 0x0000ABCD: mem_write=1, mem_funct3=001, mem_wd=0x0000ABCD. rvalid0=1 and err0=0.
- Port 0 load with funct3 111: err0=1, no memory strobe.
- reset pulsed low during ACCESS: all outputs 0 immediately. No rvalid follows, and after release a tie is won by port 0.
